// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: op codes, FSM encoding,
// iteration count and the quotient returned for a divide by zero.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef logic [1:0] state_t;
   localparam state_t S_IDLE   = 2'd0;
   localparam state_t S_CALC   = 2'd1;
   localparam state_t S_FINISH = 2'd2;

   localparam int          ITERATIONS = 32;
   localparam logic [31:0] DBZ_QUOT   = 32'hFFFF_FFFF;

   // Magnitude of a two's-complement word when the operation is signed.
   function automatic logic [31:0] mag_of(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle of muldiv_unit. A request is a one-cycle start pulse
// taken only while busy is low; done is a one-cycle pulse with hi/lo already updated.
interface muldiv_if;
   import muldiv_pkg::*;

   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;
   state_t      state_dbg;

   modport master (
      output start, op, a, b, wr_hi, wr_lo, wr_data,
      input  busy, done, div_by_zero, hi, lo, state_dbg
   );

   modport slave (
      input  start, op, a, b, wr_hi, wr_lo, wr_data,
      output busy, done, div_by_zero, hi, lo, state_dbg
   );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply on {acc_hi,acc_lo}, or a
// restoring subtract step for divide (acc_hi = remainder, acc_lo = quotient/dividend).
module muldiv_step (
   input  logic        is_div,
   input  logic [31:0] acc_hi,
   input  logic [31:0] acc_lo,
   input  logic [31:0] opnd,
   output logic [31:0] nxt_hi,
   output logic [31:0] nxt_lo
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic        fits;

   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
      shifted = {acc_hi, acc_lo[31]};
      fits    = (shifted >= {1'b0, opnd});
      nxt_hi  = sum[32:1];
      nxt_lo  = {sum[0], acc_lo[31:1]};
      if (is_div) begin
         // Remainder stays below the divisor, so the 32-bit difference is exact.
         nxt_hi = fits ? (shifted[31:0] - opnd) : shifted[31:0];
         nxt_lo = {acc_lo[30:0], fits};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (mult, multu, div, divu, mthi/mtlo).
// Define MULDIV_FAST_MUL_EN to form multiply products in a single cycle.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   state_t      state;
   logic [5:0]  count;
   logic [1:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] opnd_q;
   logic [31:0] acc_hi;
   logic [31:0] acc_lo;
   logic        neg_q;
   logic        rem_neg_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;
   logic        dbz_q;

   logic        in_signed;
   logic        in_div;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        q_div;
   logic [31:0] step_hi;
   logic [31:0] step_lo;
   logic [63:0] prod_fix;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   assign in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
   assign in_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
   assign a_mag     = mag_of(bus.a, in_signed);
   assign b_mag     = mag_of(bus.b, in_signed);
   assign q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);

   muldiv_step u_step (
      .is_div (q_div),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .opnd   (opnd_q),
      .nxt_hi (step_hi),
      .nxt_lo (step_lo)
   );

   // Sign correction on the unsigned magnitude result, applied in FINISH.
   always_comb begin
      prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      res_hi   = prod_fix[63:32];
      res_lo   = prod_fix[31:0];
      if (q_div) begin
         res_hi = rem_neg_q ? -acc_hi : acc_hi;
         res_lo = neg_q ? -acc_lo : acc_lo;
         if (opnd_q == 32'd0) begin
            res_hi = a_q;
            res_lo = DBZ_QUOT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= 6'd0;
         op_q      <= OP_MULT;
         a_q       <= 32'd0;
         opnd_q    <= 32'd0;
         acc_hi    <= 32'd0;
         acc_lo    <= 32'd0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op_q      <= bus.op;
                  a_q       <= bus.a;
                  count     <= 6'd0;
                  neg_q     <= in_signed && (bus.a[31] ^ bus.b[31]);
                  rem_neg_q <= in_signed && bus.a[31];
                  acc_hi    <= 32'd0;
                  acc_lo    <= in_div ? a_mag : b_mag;
                  opnd_q    <= in_div ? b_mag : a_mag;
                  state     <= S_CALC;
               end else begin
                  if (bus.wr_hi) hi_q <= bus.wr_data;
                  if (bus.wr_lo) lo_q <= bus.wr_data;
               end
            end
            S_CALC: begin
`ifdef MULDIV_FAST_MUL_EN
               if (!q_div) begin
                  {acc_hi, acc_lo} <= {32'd0, opnd_q} * {32'd0, acc_lo};
                  state            <= S_FINISH;
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  count  <= count + 6'd1;
                  if (count == 6'(ITERATIONS - 1)) state <= S_FINISH;
               end
`else
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count + 6'd1;
               if (count == 6'(ITERATIONS - 1)) state <= S_FINISH;
`endif
            end
            S_FINISH: begin
               hi_q   <= res_hi;
               lo_q   <= res_lo;
               done_q <= 1'b1;
               dbz_q  <= q_div && (opnd_q == 32'd0);
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.state_dbg   = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of operations with hand-computed
// results and latencies, plus busy-injection, direct-write and mid-op reset sequences.
module tb_muldiv_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int LAT_MUL = 2;
   localparam int INJ     = 1;
`else
   localparam int LAT_MUL = 33;
   localparam int INJ     = 5;
`endif
   localparam int LAT_DIV = 33;

   logic clk;
   logic rst;
   muldiv_if bus();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Issue one op and wait (bounded) for done; lat counts edges after the start edge.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r_hi, output logic [31:0] r_lo,
                         output logic r_dbz, output logic r_busy, output int lat);
      @(negedge clk);
      bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      r_hi = bus.hi; r_lo = bus.lo; r_dbz = bus.div_by_zero; r_busy = bus.busy;
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   vec_t vecs[12];

   logic [31:0] r_hi, r_lo;
   logic        r_dbz, r_busy;
   int          lat;
   int          done_seen;

   initial begin
      vecs[0]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{"mult_m3x7",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vecs[2]  = '{"div_m7d2",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{"divu_100d0", OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
      vecs[4]  = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[5]  = '{"divu_100d7", OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
      vecs[6]  = '{"mult_minsq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[7]  = '{"div_7dm2",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[8]  = '{"div_m8d0",   OP_DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{"multu_sh4",  OP_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0};
      vecs[10] = '{"div_m7dm2",  OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      vecs[11] = '{"mult_0xm5",  OP_MULT,  32'd0,        32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0};

      rst = 1'b1;
      bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0;
      bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
      check("rst_hi",   bus.hi, 32'd0);
      check("rst_lo",   bus.lo, 32'd0);
      check("rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dbz, r_busy, lat);
         check({vecs[i].name, "_hi"},   r_hi, vecs[i].exp_hi);
         check({vecs[i].name, "_lo"},   r_lo, vecs[i].exp_lo);
         check({vecs[i].name, "_dbz"},  32'(r_dbz), 32'(vecs[i].exp_dbz));
         check({vecs[i].name, "_busy"}, 32'(r_busy), 32'd0);
         check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].op[1] ? LAT_DIV : LAT_MUL));
      end

      // start + wr_hi injected while a multiply is busy: both ignored.
      @(negedge clk);
      bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      repeat (INJ) begin @(negedge clk); lat++; end
      check("inj_busy", 32'(bus.busy), 32'd1);
      bus.op = OP_DIVU; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
      bus.wr_hi = 1'b1; bus.wr_data = 32'hDEADBEEF;
      @(negedge clk);
      lat++;
      bus.start = 1'b0; bus.wr_hi = 1'b0;
      while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
      check("inj_hi",  bus.hi, 32'd0);
      check("inj_lo",  bus.lo, 32'd15);
      check("inj_lat", 32'(lat), 32'(LAT_MUL));
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check("inj_no_second_done", 32'(done_seen), 32'd0);

      // Direct writes in IDLE.
      bus.wr_lo = 1'b1; bus.wr_data = 32'h1234;
      @(negedge clk);
      bus.wr_lo = 1'b0;
      check("mtlo_lo", bus.lo, 32'h1234);
      check("mtlo_hi", bus.hi, 32'd0);
      bus.wr_hi = 1'b1; bus.wr_data = 32'h5678;
      @(negedge clk);
      bus.wr_hi = 1'b0;
      check("mthi_hi", bus.hi, 32'h5678);
      check("mthi_lo", bus.lo, 32'h1234);

      // start and wr_hi together: start wins, write discarded.
      bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
      bus.wr_hi = 1'b1; bus.wr_data = 32'hAAAA;
      @(negedge clk);
      bus.start = 1'b0; bus.wr_hi = 1'b0;
      check("prio_hi_held", bus.hi, 32'h5678);
      lat = 0;
      while (!bus.done && lat < 200) begin @(negedge clk); lat++; end
      check("prio_hi", bus.hi, 32'd0);
      check("prio_lo", bus.lo, 32'd6);

      // Reset at cycle 10 of a divide.
      @(negedge clk);
      bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy",  32'(bus.busy), 32'd0);
      check("mid_rst_hi",    bus.hi, 32'd0);
      check("mid_rst_lo",    bus.lo, 32'd0);
      check("mid_rst_state", 32'(bus.state_dbg), 32'(S_IDLE));
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.done) done_seen++;
      end
      check("mid_rst_no_done", 32'(done_seen), 32'd0);
      check("mid_rst_lo_held", bus.lo, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
